// File: rtl/crack_ctrl.sv
// Brute-force key-search controller: runs arc4 once per candidate key and stops
// on the first key whose length-prefixed plaintext is entirely printable ASCII.
module crack_ctrl #(
  parameter logic [23:0] KEY_FIRST = 24'h000000,
  parameter logic [23:0] KEY_LAST  = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic        key_valid,
  output logic [23:0] key,
  output logic        a4_en,
  input  logic        a4_rdy,
  output logic [23:0] a4_key,
  input  logic [7:0]  a4_pt_addr,
  input  logic [7:0]  a4_pt_wrdata,
  input  logic        a4_pt_wren,
  output logic [7:0]  pt_addr,
  output logic [7:0]  pt_wrdata,
  output logic        pt_wren,
  input  logic [7:0]  pt_rddata
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_START     = 4'd1;
  localparam logic [3:0] S_WAIT_BUSY = 4'd2;
  localparam logic [3:0] S_WAIT_DONE = 4'd3;
  localparam logic [3:0] S_RD_LEN    = 4'd4;
  localparam logic [3:0] S_LEN       = 4'd5;
  localparam logic [3:0] S_RD_BYTE   = 4'd6;
  localparam logic [3:0] S_CHK_BYTE  = 4'd7;
  localparam logic [3:0] S_NEXT      = 4'd8;
  localparam logic [3:0] S_FOUND     = 4'd9;

  logic [3:0] state;
  logic [7:0] len;
  logic [7:0] idx;
  logic       arc4_owns_mem;
  logic       byte_bad;

  assign byte_bad = (pt_rddata < 8'h20) || (pt_rddata > 8'h7E);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      key       <= 24'h000000;
      key_valid <= 1'b0;
      len       <= 8'h00;
      idx       <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            key       <= KEY_FIRST;
            key_valid <= 1'b0;
            state     <= S_START;
          end
        end
        S_START:     state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (!a4_rdy) state <= S_WAIT_DONE;
        S_WAIT_DONE: if (a4_rdy) state <= S_RD_LEN;
        S_RD_LEN:    state <= S_LEN;
        S_LEN: begin
          len   <= pt_rddata;
          idx   <= 8'd1;
          state <= (pt_rddata == 8'h00) ? S_FOUND : S_RD_BYTE;
        end
        S_RD_BYTE:   state <= S_CHK_BYTE;
        // idx stops at len, so a 255-byte string ends at address 255 without wrapping
        S_CHK_BYTE: begin
          if (byte_bad) begin
            state <= S_NEXT;
          end else if (idx == len) begin
            state <= S_FOUND;
          end else begin
            idx   <= idx + 8'd1;
            state <= S_RD_BYTE;
          end
        end
        S_NEXT: begin
          if (key == KEY_LAST) begin
            state <= S_IDLE;
          end else begin
            key   <= key + 24'd1;
            state <= S_START;
          end
        end
        S_FOUND: begin
          key_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default:     state <= S_IDLE;
      endcase
    end
  end

  // arc4 only reaches pt_mem while we wait on it; elsewhere the checker reads
  assign arc4_owns_mem = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);

  always_comb begin
    rdy       = (state == S_IDLE);
    a4_en     = (state == S_START);
    a4_key    = key;
    pt_addr   = (state == S_RD_BYTE) ? idx : 8'h00;
    pt_wrdata = 8'h00;
    pt_wren   = 1'b0;
    if (arc4_owns_mem) begin
      pt_addr   = a4_pt_addr;
      pt_wrdata = a4_pt_wrdata;
      pt_wren   = a4_pt_wren;
    end
  end

endmodule

// File: tb/tb_crack_ctrl.sv
// Bench for crack_ctrl: behavioural arc4 and pt_mem models, per-search plaintext
// tables, and a scoreboard checked whenever the controller returns to ready.
module tb_crack_ctrl;

  localparam logic [23:0] KF = 24'h000018;
  localparam logic [23:0] KL = 24'h00001F;
  localparam int NK = 8;
  localparam int LIMIT = 20000;
  localparam int PH_IDLE = 0;
  localparam int PH_WR   = 1;
  localparam int PH_DLY  = 2;
  localparam int PH_COOL = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic        key_valid;
  logic [23:0] key;
  logic        a4_en;
  logic        a4_rdy;
  logic [23:0] a4_key;
  logic [7:0]  a4_pt_addr;
  logic [7:0]  a4_pt_wrdata;
  logic        a4_pt_wren;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_wrdata;
  logic        pt_wren;
  logic [7:0]  pt_rddata;

  crack_ctrl #(.KEY_FIRST(KF), .KEY_LAST(KL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key_valid(key_valid), .key(key),
    .a4_en(a4_en), .a4_rdy(a4_rdy), .a4_key(a4_key),
    .a4_pt_addr(a4_pt_addr), .a4_pt_wrdata(a4_pt_wrdata), .a4_pt_wren(a4_pt_wren),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren), .pt_rddata(pt_rddata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [23:0] key;
    int          pulses;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;

  logic [7:0] pt_len_tab [NK];
  logic [7:0] pt_byte_tab [NK][256];
  int         delay_tab [NK];

  logic        last_valid;
  logic [23:0] last_key;
  int          m_phase;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Synchronous-read plaintext memory
  logic [7:0] mem [256];
  initial for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  always @(posedge clk) begin
    if (pt_wren) mem[pt_addr] <= pt_wrdata;
    pt_rddata <= mem[pt_addr];
  end

  // arc4 model: on a start pulse, goes busy, writes len + bytes for that key,
  // waits delay_tab cycles, then returns ready; otherwise emits junk writes.
  initial begin
    int saw_en;
    logic [23:0] saw_key;
    int cur, widx, cnt;
    a4_rdy = 1'b1; a4_pt_wren = 1'b0; a4_pt_addr = 8'h00; a4_pt_wrdata = 8'h00;
    m_phase = PH_IDLE; cur = 0; widx = 0; cnt = 0;
    forever begin
      @(negedge clk);
      saw_en = int'(a4_en);
      saw_key = a4_key;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        a4_rdy = 1'b1; a4_pt_wren = 1'b0; a4_pt_addr = 8'h00; a4_pt_wrdata = 8'h00;
        m_phase = PH_IDLE;
      end else begin
        case (m_phase)
          PH_IDLE: begin
            if (saw_en != 0) begin
              cur = int'(saw_key) - int'(KF);
              if (cur < 0 || cur >= NK) cur = 0;
              a4_rdy = 1'b0;
              widx = 0;
              a4_pt_wren = 1'b1; a4_pt_addr = 8'h00; a4_pt_wrdata = pt_len_tab[cur];
              m_phase = PH_WR;
            end else begin
              a4_pt_wren = 1'($urandom_range(0, 1));
              a4_pt_addr = 8'($urandom);
              a4_pt_wrdata = 8'($urandom);
            end
          end
          PH_WR: begin
            widx++;
            if (widx <= int'(pt_len_tab[cur])) begin
              a4_pt_addr = 8'(widx);
              a4_pt_wrdata = pt_byte_tab[cur][widx];
            end else begin
              a4_pt_wren = 1'b0;
              if (delay_tab[cur] == 0) begin
                a4_rdy = 1'b1; m_phase = PH_COOL; cnt = 2;
              end else begin
                m_phase = PH_DLY; cnt = delay_tab[cur];
              end
            end
          end
          PH_DLY: begin
            cnt--;
            if (cnt == 0) begin
              a4_rdy = 1'b1; m_phase = PH_COOL; cnt = 2;
            end
          end
          default: begin
            a4_pt_wren = 1'b0;
            cnt--;
            if (cnt == 0) m_phase = PH_IDLE;
          end
        endcase
      end
    end
  end

  // Monitor: arbitration checks every cycle, scoreboard pop on each return to ready
  initial begin
    int mon_busy, mon_pulses;
    logic prev_rdy;
    exp_t e;
    mon_busy = 0; mon_pulses = 0; prev_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_busy = 0; mon_pulses = 0; prev_rdy = 1'b1;
      end else begin
        if (!rdy) mon_busy++;
        if (a4_en) mon_pulses++;
        if (m_phase == PH_WR && a4_pt_wren)
          check_output("pt_passthrough", {15'h0, pt_wren, pt_addr, pt_wrdata},
                       {15'h0, 1'b1, a4_pt_addr, a4_pt_wrdata});
        if (m_phase == PH_IDLE && a4_pt_wren)
          check_output("pt_drop", {23'h0, pt_wren, pt_wrdata}, 32'h0);
        if (rdy && !prev_rdy) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_done", 32'h1, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check_output("key_valid", 32'(key_valid), 32'(e.valid));
            check_output("key", 32'(key), 32'(e.key));
            check_output("a4_en_pulses", 32'(mon_pulses), 32'(e.pulses));
            check_output("busy_cycles", 32'(mon_busy), 32'(e.cycles));
            last_valid = e.valid;
            last_key = e.key;
          end
          mon_busy = 0; mon_pulses = 0;
        end
        prev_rdy = rdy;
      end
    end
  end

  // Reference: first key whose plaintext bytes all lie in 0x20..0x7E, with
  // cost 1 + busy + 2 + 2 per byte read + 1 per candidate.
  function automatic exp_t compute_expected();
    exp_t e;
    int checked;
    bit bad;
    e.valid = 1'b0; e.key = KL; e.pulses = 0; e.cycles = 0;
    for (int k = 0; k < NK; k++) begin
      e.pulses++;
      checked = 0; bad = 1'b0;
      for (int b = 1; b <= int'(pt_len_tab[k]); b++) begin
        checked++;
        if (pt_byte_tab[k][b] < 8'h20 || pt_byte_tab[k][b] > 8'h7E) begin
          bad = 1'b1;
          break;
        end
      end
      e.cycles += 1 + (int'(pt_len_tab[k]) + 2 + delay_tab[k]) + 2 + 2 * checked + 1;
      if (!bad) begin
        e.valid = 1'b1;
        e.key = KF + 24'(k);
        break;
      end
    end
    return e;
  endfunction

  function automatic logic [7:0] rand_printable();
    int r;
    r = int'($urandom_range(0, 5));
    if (r == 0) return 8'h20;
    if (r == 1) return 8'h7E;
    return 8'(32'h20 + $urandom_range(0, 94));
  endfunction

  function automatic logic [7:0] rand_bad();
    case ($urandom_range(0, 5))
      0: return 8'h1F;
      1: return 8'h7F;
      2: return 8'h00;
      3: return 8'hFF;
      4: return 8'($urandom_range(0, 31));
      default: return 8'($urandom_range(127, 255));
    endcase
  endfunction

  task automatic fill_entry(input int k, input int len, input int badpos,
                            input logic [7:0] badval, input int d);
    pt_len_tab[k] = 8'(len);
    pt_byte_tab[k][0] = 8'h00;
    for (int b = 1; b < 256; b++) pt_byte_tab[k][b] = rand_printable();
    if (badpos > 0) pt_byte_tab[k][badpos] = badval;
    delay_tab[k] = d;
  endtask

  task automatic fill_random();
    int len;
    for (int k = 0; k < NK; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        len = int'($urandom_range(0, 10));
        fill_entry(k, len, 0, 8'h00, int'($urandom_range(0, 3)));
      end else begin
        len = int'($urandom_range(1, 10));
        fill_entry(k, len, int'($urandom_range(1, len)), rand_bad(), int'($urandom_range(0, 3)));
      end
    end
  endtask

  task automatic abort_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    last_valid = 1'b0;
    last_key = 24'h0;
  endtask

  task automatic issue_en();
    @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    check_output("accept_rdy", 32'(rdy), 32'h0);
    check_output("accept_key_valid", 32'(key_valid), 32'h0);
    check_output("accept_a4_en", 32'(a4_en), 32'h1);
    check_output("accept_key", 32'(key), 32'(KF));
  endtask

  // One search: push the model's answer, start, then poke en while busy
  task automatic apply_stimulus();
    int cyc;
    check_output("hold_key_valid", 32'(key_valid), 32'(last_valid));
    check_output("hold_key", 32'(key), 32'(last_key));
    exp_q.push_back(compute_expected());
    issue_en();
    cyc = 0;
    while (!rdy && cyc < LIMIT) begin
      en = ($urandom_range(0, 7) == 0);
      @(posedge clk);
      #1;
      if (rdy) en = 1'b0;
      cyc++;
    end
    en = 1'b0;
    if (cyc >= LIMIT) begin
      check_output("search_timeout", 32'(cyc), 32'(LIMIT - 1));
      abort_reset();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic reset_abort_test();
    int cyc;
    for (int k = 0; k < NK; k++) fill_entry(k, 6, 6, 8'h7F, 3);
    issue_en();
    cyc = 0;
    while (m_phase != PH_WR && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_output("reset_reach_wait", 32'(cyc < 100), 32'h1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_rdy", 32'(rdy), 32'h1);
    check_output("abort_key_valid", 32'(key_valid), 32'h0);
    check_output("abort_key", 32'(key), 32'h0);
    check_output("abort_a4_en", 32'(a4_en), 32'h0);
    check_output("abort_pt_bus", {15'h0, pt_wren, pt_addr, pt_wrdata}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_output("abort_rdy_after", 32'(rdy), 32'h1);
    last_valid = 1'b0;
    last_key = 24'h0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int len;
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    rst_n = 1'b0;
    en = 1'b0;
    last_valid = 1'b0;
    last_key = 24'h0;
    for (int k = 0; k < NK; k++) fill_entry(k, 1, 1, 8'h00, 0);
    #3;
    check_output("reset_rdy", 32'(rdy), 32'h1);
    check_output("reset_key_valid", 32'(key_valid), 32'h0);
    check_output("reset_key", 32'(key), 32'h0);
    check_output("reset_a4_key", 32'(a4_key), 32'h0);
    check_output("reset_a4_en", 32'(a4_en), 32'h0);
    check_output("reset_pt_bus", {15'h0, pt_wren, pt_addr, pt_wrdata}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] hit on first key");
    for (int k = 0; k < NK; k++) fill_entry(k, 4, 2, 8'h07, 1);
    fill_entry(0, 3, 0, 8'h00, 0);
    pt_byte_tab[0][1] = 8'h61; pt_byte_tab[0][2] = 8'h62; pt_byte_tab[0][3] = 8'h63;
    apply_stimulus();

    $display("[TB] hit after five misses");
    for (int k = 0; k < 5; k++) begin
      len = int'($urandom_range(1, 6));
      fill_entry(k, len, int'($urandom_range(1, len)), 8'h07, int'($urandom_range(0, 2)));
    end
    fill_entry(5, 2, 0, 8'h00, 2);
    pt_byte_tab[5][1] = 8'h4F; pt_byte_tab[5][2] = 8'h4B;
    apply_stimulus();

    $display("[TB] exhausted range");
    for (int k = 0; k < NK; k++) fill_entry(k, 4, int'($urandom_range(1, 4)), 8'h7F, int'($urandom_range(0, 2)));
    apply_stimulus();

    $display("[TB] printable boundaries");
    for (int k = 0; k < NK; k++) fill_entry(k, 3, 1, 8'h1F, 0);
    fill_entry(0, 3, 2, 8'h1F, 0); pt_byte_tab[0][1] = 8'h20;
    fill_entry(1, 2, 2, 8'h7F, 1); pt_byte_tab[1][1] = 8'h7E;
    fill_entry(2, 2, 0, 8'h00, 0); pt_byte_tab[2][1] = 8'h20; pt_byte_tab[2][2] = 8'h7E;
    apply_stimulus();

    $display("[TB] empty plaintext");
    for (int k = 0; k < NK; k++) fill_entry(k, 1, 1, 8'h1F, 0);
    fill_entry(3, 0, 0, 8'h00, 1);
    apply_stimulus();

    $display("[TB] 255-byte plaintexts");
    fill_entry(0, 255, 255, 8'h7F, 0);
    for (int b = 1; b < 255; b++) pt_byte_tab[0][b] = 8'h41;
    fill_entry(1, 255, 0, 8'h00, 0);
    for (int b = 1; b < 256; b++) pt_byte_tab[1][b] = 8'h41;
    apply_stimulus();

    $display("[TB] reset during arc4 run");
    reset_abort_test();

    $display("[TB] randomized searches");
    for (int n = 0; n < 14; n++) begin
      fill_random();
      apply_stimulus();
    end

    repeat (5) @(posedge clk);
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/crack_ctrl.md
# crack_ctrl

Brute-force key-search controller for the ARC4 decrypt datapath. It steps a 24-bit key through a configured range. For each candidate it starts `arc4` with a one-cycle enable and waits for `arc4` to finish. It then scans the length-prefixed plaintext in `pt_mem` and stops on the first key whose plaintext is entirely printable ASCII. It owns the `pt_mem` port and arbitrates it between `arc4` (writes) and its own checker (reads).

## Interface
Parameters:
- KEY_FIRST, 24'h000000, first candidate key tried
- KEY_LAST, 24'hFFFFFF, last candidate key tried (inclusive; KEY_LAST >= KEY_FIRST)

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- en  in  1  start request; accepted only in a cycle where rdy=1
- rdy  out  1  1 = idle and able to accept en
- key_valid  out  1  1 = last search found a key; held until next accepted en
- key  out  24  found key when key_valid=1, else current candidate
- a4_en  out  1  one-cycle start pulse to arc4
- a4_rdy  in  1  arc4 ready/idle
- a4_key  out  24  key driven to arc4; equals key
- a4_pt_addr, a4_pt_wrdata  in  8 each  arc4 plaintext write address/data
- a4_pt_wren  in  1  arc4 plaintext write enable
- pt_addr  out  8  pt_mem address
- pt_wrdata  out  8  pt_mem write data
- pt_wren  out  1  pt_mem write enable
- pt_rddata  in  8  pt_mem read data; synchronous, valid 1 cycle after pt_addr

## Operation
States and transitions:
- IDLE: rdy=1. On en: key<=KEY_FIRST, key_valid<=0, go to START.
- START: a4_en=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: wait for a4_rdy=0, then go to WAIT_DONE.
- WAIT_DONE: wait for a4_rdy=1, then go to RD_LEN.
- RD_LEN: pt_addr=0; go to LEN.
- LEN: len<=pt_rddata, i<=1. If pt_rddata=0 go to FOUND (empty string passes); else go to RD_BYTE.
- RD_BYTE: pt_addr=i; go to CHK_BYTE.
- CHK_BYTE: byte fails if pt_rddata < 8'h20 or > 8'h7E.
  - Fail: go to NEXT.
  - Pass and i==len: go to FOUND.
  - Otherwise: i<=i+1 and go to RD_BYTE.
- NEXT: if key==KEY_LAST, go to IDLE with key_valid=0 (exhausted, key holds KEY_LAST). Else key<=key+1 and go to START.
- FOUND: key_valid<=1, key frozen; go to IDLE.

Arbitration and datapath rules:
- In WAIT_BUSY and WAIT_DONE, pt_addr/pt_wrdata/pt_wren pass through a4_pt_*.
- In all other states, pt_wren=0, pt_wrdata=0 and pt_addr=checker address. arc4 writes outside the wait states are dropped.
- i and len are 8-bit unsigned; len=255 scans bytes 1..255 with no wrap.
- key increments only in NEXT; it never wraps past KEY_LAST.
- en while rdy=0 is ignored with no effect.

## Timing
- Reset values: rdy=1, key_valid=0, key=0, a4_key=0, a4_en=0, pt_addr=0, pt_wrdata=0, pt_wren=0, state IDLE.
- rst_n low mid-search aborts immediately to the reset values. arc4 shares rst_n.
- en accepted in cycle t: rdy=0 and key_valid=0 at t+1; a4_en=1 at t+1 only.
- Per-candidate cost is 1 (START) + arc4 busy time + 2 (length read) + 2 per byte checked + 1 (NEXT).
- First failing byte aborts the scan at once; remaining bytes are not read.
- After FOUND or exhaustion, rdy=1 the cycle after the final state. key_valid and key then hold stable until the next accepted en.
- a4_en is never asserted twice without an intervening a4_rdy 0 to 1 sequence.

## Test plan
- Reset: assert rst_n=0 mid-WAIT_DONE -> all outputs return to reset values in the same cycle; rdy=1 after release.
- Hit on first key: KEY_FIRST=24'h000018, arc4 model writes len=3, "abc" -> one a4_en pulse, key_valid=1, key=24'h000018.
- Hit after misses: model outputs byte 0x07 for keys 0..4 and "OK" (len 2) for key 5 -> exactly 6 a4_en pulses, key=5, key_valid=1.
- Exhausted: KEY_FIRST=0, KEY_LAST=3, all plaintexts contain 0x7F -> 4 pulses, rdy=1, key_valid=0, key=3.
- Boundaries: len=0 passes immediately. Bytes 0x20 and 0x7E pass, bytes 0x1F and 0x7F fail. len=255 with all 'A' checks 255 bytes with no address wrap.
- Handshake: en pulsed while rdy=0 -> ignored. During WAIT_* states pt_wren mirrors a4_pt_wren; in other states pt_wren=0 even if a4_pt_wren=1.
